// File: rtl/cmd_decoder_pkg.sv
// rtl/cmd_decoder_pkg.sv - shared framing constants and decoder state type
package cmd_decoder_pkg;

    // Shared with the transmit-side encoder so both ends agree on framing.
    localparam logic [7:0] DEF_PREFIX   = 8'hAA;
    localparam logic [7:0] DEF_ADDR_AST = 8'h01;
    localparam int         DEF_N_SRC    = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DEST = 3'd2,
        ST_GET_LEN  = 3'd3,
        ST_GET_DATA = 3'd4,
        ST_GET_CRC  = 3'd5
    } state_t;

endpackage

// File: rtl/cmd_decoder_byte_gap_timer.sv
// rtl/cmd_decoder_byte_gap_timer.sv - idle-clock counter between bytes of a frame
module byte_gap_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    assign expired = en && (cnt == W'(TIMEOUT));

    // Saturates at TIMEOUT; the owner leaves its frame state, which drops en.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cmd_decoder.sv
// rtl/cmd_decoder.sv - receive-side frame parser steering payload into destination FIFOs
module cmd_decoder
    import cmd_decoder_pkg::*;
#(
    parameter int         N_DST   = DEF_N_SRC,
    parameter logic [7:0] PREFIX  = DEF_PREFIX,
    parameter logic [7:0] MY_ADDR = DEF_ADDR_AST,
    parameter int         TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic [N_DST-1:0] full_bus,
    output logic [7:0]       wr_data,
    output logic [N_DST-1:0] wrreq_bus,
    output logic             pkt_done,
    output logic             pkt_ok,
    output logic [7:0]       pkt_dest,
    output logic             err_timeout
);

    state_t     state, state_nxt;
    logic [7:0] dest_r, dest_nxt;
    logic [7:0] len_r, len_nxt;
    logic [7:0] cnt_r, cnt_nxt;
    logic [7:0] crc_r, crc_nxt;
    logic       bad_r, bad_nxt;

    logic [7:0]       wr_data_nxt;
    logic [N_DST-1:0] wrreq_nxt;
    logic             done_nxt;
    logic             ok_nxt;
    logic [7:0]       pdest_nxt;
    logic             to_nxt;

    logic             expired;
    logic             dest_full;
    logic [N_DST-1:0] dest_onehot;

    byte_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .en      (state != ST_IDLE),
        .clr     (rx_valid),
        .expired (expired)
    );

    // Decode the 8-bit dest against the vector width without out-of-range indexing.
    always_comb begin
        dest_full   = 1'b0;
        dest_onehot = '0;
        for (int i = 0; i < N_DST; i++) begin
            if (dest_r == 8'(i)) begin
                dest_full      = full_bus[i];
                dest_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        dest_nxt    = dest_r;
        len_nxt     = len_r;
        cnt_nxt     = cnt_r;
        crc_nxt     = crc_r;
        bad_nxt     = bad_r;
        wr_data_nxt = wr_data;
        wrreq_nxt   = '0;
        done_nxt    = 1'b0;
        ok_nxt      = pkt_ok;
        pdest_nxt   = pkt_dest;
        to_nxt      = 1'b0;

        if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_data == PREFIX) begin
                        state_nxt = ST_GET_ADDR;
                    end
                end
                ST_GET_ADDR: begin
                    state_nxt = (rx_data == MY_ADDR) ? ST_GET_DEST : ST_IDLE;
                end
                ST_GET_DEST: begin
                    dest_nxt  = rx_data;
                    bad_nxt   = (32'(rx_data) >= N_DST);
                    state_nxt = ST_GET_LEN;
                end
                ST_GET_LEN: begin
                    len_nxt   = rx_data;
                    cnt_nxt   = '0;
                    crc_nxt   = '0;
                    state_nxt = (rx_data != 8'd0) ? ST_GET_DATA : ST_GET_CRC;
                end
                ST_GET_DATA: begin
                    crc_nxt = crc_r + rx_data;
                    cnt_nxt = cnt_r + 8'd1;
                    if (!bad_r) begin
                        if (dest_full) begin
                            bad_nxt = 1'b1;
                        end else begin
                            wr_data_nxt = rx_data;
                            wrreq_nxt   = dest_onehot;
                        end
                    end
                    if (cnt_nxt == len_r) begin
                        state_nxt = ST_GET_CRC;
                    end
                end
                ST_GET_CRC: begin
                    done_nxt  = 1'b1;
                    ok_nxt    = !bad_r && (rx_data == crc_r);
                    pdest_nxt = dest_r;
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end else if (expired) begin
            to_nxt    = 1'b1;
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= ST_IDLE;
            dest_r      <= '0;
            len_r       <= '0;
            cnt_r       <= '0;
            crc_r       <= '0;
            bad_r       <= 1'b0;
            wr_data     <= '0;
            wrreq_bus   <= '0;
            pkt_done    <= 1'b0;
            pkt_ok      <= 1'b0;
            pkt_dest    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            dest_r      <= dest_nxt;
            len_r       <= len_nxt;
            cnt_r       <= cnt_nxt;
            crc_r       <= crc_nxt;
            bad_r       <= bad_nxt;
            wr_data     <= wr_data_nxt;
            wrreq_bus   <= wrreq_nxt;
            pkt_done    <= done_nxt;
            pkt_ok      <= ok_nxt;
            pkt_dest    <= pdest_nxt;
            err_timeout <= to_nxt;
        end
    end

endmodule

// File: doc/cmd_decoder.md
# cmd_decoder

Receive-side packet parser for the host link. Consumes the byte stream from the UART receiver, validates prefix, address, destination, length and additive CRC, and steers payload bytes into per-destination write FIFOs. It terminates the same framing the transmit-side encoder produces, in the opposite direction, and reports a per-packet status strobe.

## Interface
- `N_DST`, default 8: number of destination FIFOs; the destination field is compared against it.
- `PREFIX`, default 8'hAA: frame start byte.
- `MY_ADDR`, default 8'h01: device address byte; frames with any other address are ignored.
- `TIMEOUT`, default 1000: maximum idle clocks between bytes inside a frame.
- `clk` in 1: system clock.
- `n_rst` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte; valid only when `rx_valid` is high.
- `rx_valid` in 1: single-cycle strobe, one per byte. There is no backpressure toward the receiver.
- `full_bus` in N_DST: per-destination FIFO full flags.
- `wr_data` out 8: payload byte to the FIFOs, shared by all destinations.
- `wrreq_bus` out N_DST: one-hot write strobe. Only the addressed destination bit is ever set.
- `pkt_done` out 1: one-cycle pulse at the end of every frame, whether it passed or failed.
- `pkt_ok` out 1: qualifies `pkt_done`. High means the CRC matched, the destination was valid, and no byte overflowed.
- `pkt_dest` out 8: destination field of the frame being reported.
- `err_timeout` out 1: one-cycle pulse when a frame is abandoned because of a byte gap.

## Operation
- Frame format, in order: PREFIX, ADDR, DEST, LEN, then LEN data bytes, then CRC. CRC = sum of the data bytes mod 256. LEN=0 is legal and its CRC must be 8'h00.
- States: IDLE, GET_ADDR, GET_DEST, GET_LEN, GET_DATA, GET_CRC.
- Every transition happens only on a cycle with `rx_valid`=1.
- IDLE: if the byte equals PREFIX, go to GET_ADDR. Any other byte is discarded and the state stays IDLE.
- GET_ADDR: if the byte equals MY_ADDR, go to GET_DEST. Otherwise return to IDLE with no status pulse.
- GET_DEST: latch the byte as dest. Set `bad` = (dest >= N_DST). Go to GET_LEN.
- GET_LEN: latch len. Clear cnt and crc to 0. Go to GET_DATA if len != 0, otherwise go to GET_CRC.
- GET_DATA, on each byte:
  - Add the byte to crc (8-bit wrap) and increment cnt.
  - If !bad and !full_bus[dest]: drive `wr_data` = byte and `wrreq_bus` = 1<<dest.
  - If !bad and full_bus[dest]: drop the byte and set `bad`. Later bytes of the frame are not written either.
  - When cnt reaches len after the increment, go to GET_CRC.
- GET_CRC: pulse `pkt_done`. Drive `pkt_ok` = !bad && (byte == crc) and `pkt_dest` = dest. Return to IDLE.
- No rollback: bytes already written to a FIFO stay there on a CRC failure. The consumer uses `pkt_ok` to accept or flush them.
- A PREFIX-valued byte seen outside IDLE is treated as ordinary data; the decoder does not resync on it.
- Gap timer:
  - Counts clocks while state != IDLE and `rx_valid`=0, and clears on every `rx_valid`.
  - On reaching TIMEOUT: pulse `err_timeout` and return to IDLE.
  - No `pkt_done` is issued for a timed-out frame.
  - The timer is held at 0 in IDLE.
- Reset values: state IDLE; all counters 0; `wr_data` 0; `wrreq_bus` 0; `pkt_done` 0; `pkt_ok` 0; `pkt_dest` 0; `err_timeout` 0.
- Reset mid-frame discards the frame immediately. No status is emitted.

## Timing
- All outputs are registered.
- `wrreq_bus` and `wr_data` are asserted in the clock after the data byte's `rx_valid`, for exactly one cycle.
- `full_bus` is sampled in the same cycle as `rx_valid`.
- `pkt_done` follows the CRC byte's `rx_valid` by 1 clock.
- `pkt_ok` and `pkt_dest` hold their values until the next `pkt_done`.
- Back-to-back `rx_valid` on consecutive clocks is supported; throughput is one byte per clock.
- A PREFIX arriving on the clock right after the CRC byte is accepted, because the state is already IDLE.
- `err_timeout` fires on the clock the timer equals TIMEOUT. A byte arriving on that same clock wins: it is processed and the timer clears.

## Structure
- `defines.v` holds the shared constants `PREFIX`, `ADDR_AST` and `N_SRC`. These serve as the defaults of PREFIX, MY_ADDR and N_DST at instantiation, so the encoder and decoder share one source of truth.
- `defines.v` also holds the state encodings as `localparam`-style defines.
- The gap timer is a natural sub-module: `byte_gap_timer` with inputs `clk`, `n_rst`, `en`, `clr`, parameter TIMEOUT, and output `expired`.
- Debug outputs mirroring the encoder's are optional: `my_state`, `my_cnt`, `my_crc`.

## Test plan
- Good frame, as AA 01 02 03 10 20 30 60: three writes on `wrreq_bus[2]` with data 10/20/30, then `pkt_done` with `pkt_ok`=1 and `pkt_dest`=2.
- Bad CRC, as AA 01 00 02 05 06 0C: two writes to destination 0, then `pkt_done` with `pkt_ok`=0.
- Address mismatch, as AA 07 00 01 55 55: no writes and no `pkt_done`. A following valid frame is decoded correctly.
- Invalid destination and full FIFO:
  - AA 01 08 01 33 33 with N_DST=8: no writes; `pkt_done` with `pkt_ok`=0 and `pkt_dest`=8.
  - Holding `full_bus[1]` high before the 2nd data byte: exactly 1 write, then `pkt_ok`=0.
- LEN=0 and back-to-back frames:
  - AA 01 03 00 00: `pkt_done` with `pkt_ok`=1 and no writes.
  - Sent on consecutive clocks with no gaps, the next frame follows immediately and is also decoded correctly.
- Timeout and reset: stopping after AA 01 02 for TIMEOUT clocks pulses `err_timeout` once and returns to IDLE. `n_rst` asserted mid-payload clears all outputs, and the next frame decodes normally.
